imem_loader: RTL

Boot-time writer for the instruction memory: consumes a byte stream (from the UART receiver), assembles little-endian 32-bit words and drives the instruction memory write port. It holds the core in reset until a complete, checksum-verified program image has been written. It sits between the serial receiver and the imem write port, and also drives the core's reset.

---
 rtl/imem_loader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader
// ----------------------------------------------------------------------------
// Boot-time writer for the instruction memory. It takes the byte stream that
// arrives from the UART receiver, assembles little-endian 32-bit words and
// writes them through the imem write port. The core is held in reset until a
// complete program image has been written and its checksum has been verified.
//
// Image format (all multi-byte fields little-endian):
//   bytes 0..3       word count N   (1 <= N <= DEPTH, otherwise ERR)
//   next 4*N bytes   payload words
//   final byte       sum mod 256 of every payload byte (header excluded)
//
// Parameters:
//   DEPTH       instruction memory size in words, largest legal N
//   BASE_ADDR   byte address at which word 0 is written
//
// Ports:
//   i_clk        clock
//   i_reset      synchronous active-high reset
//   i_start      single-cycle pulse that begins (or restarts) a load
//   i_rx_data    stream byte
//   i_rx_valid   i_rx_data is valid
//   o_rx_ready   loader accepts a byte (HDR, DATA, CSUM)
//   o_we         imem write strobe, one cycle per word
//   o_waddr      imem byte address, word aligned, held between writes
//   o_wdata      imem write data, held between writes
//   o_cpu_reset  core reset, released only in DONE
//   o_busy       a load is in progress
//   o_done       image written and checksum matched
//   o_error      bad word count or checksum mismatch
// ============================================================================
module imem_loader #(
    parameter int          DEPTH     = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic        o_we,
    output logic [31:0] o_waddr,
    output logic [31:0] o_wdata,
    output logic        o_cpu_reset,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    // The word index has to be able to hold N itself (it reaches N just as
    // the last word is written), hence DEPTH + 1.
    localparam int IDX_W = $clog2(DEPTH + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [1:0]       byte_cnt;
    logic [23:0]      byte_shift;
    logic [31:0]      word_count;
    logic [IDX_W-1:0] word_idx;
    logic [7:0]       csum_acc;

    logic             receiving;
    logic             accept;
    logic             start_load;
    logic             fourth_byte;
    logic [31:0]      full_word;
    logic             header_bad;
    logic             last_word;
    logic             write_now;

    // ------------------------------------------------------------------------
    // Handshake and decode helpers
    // ------------------------------------------------------------------------
    assign receiving   = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    assign accept      = i_rx_valid && receiving;
    assign start_load  = i_start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign fourth_byte = (byte_cnt == 2'd3);

    // The three earlier bytes sit in byte_shift with byte 0 in the low lane,
    // so the byte arriving now completes the little-endian word on the spot.
    // The header and every payload word share this path.
    assign full_word  = {i_rx_data, byte_shift};
    assign header_bad = (full_word == 32'd0) || (full_word > 32'(DEPTH));
    assign last_word  = (32'(word_idx) == (word_count - 32'd1));
    assign write_now  = accept && (state == S_DATA) && fourth_byte;

    // ------------------------------------------------------------------------
    // Next-state logic. Bytes are only consumed in HDR/DATA/CSUM, and i_start
    // is only honoured when no load is running.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                if (accept && fourth_byte) begin
                    state_next = header_bad ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                if (accept && fourth_byte && last_word) begin
                    state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = (i_rx_data == csum_acc) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Byte assembly, word counting and checksum accumulation. A new load
    // clears the counters; byte_shift needs no clearing because every word
    // overwrites all three buffered lanes before it is used.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_cnt   <= 2'd0;
            byte_shift <= 24'd0;
            word_count <= 32'd0;
            word_idx   <= '0;
            csum_acc   <= 8'd0;
        end else if (start_load) begin
            byte_cnt   <= 2'd0;
            word_idx   <= '0;
            csum_acc   <= 8'd0;
        end else if (accept && ((state == S_HDR) || (state == S_DATA))) begin
            byte_cnt   <= byte_cnt + 2'd1;
            byte_shift <= {i_rx_data, byte_shift[23:8]};
            if ((state == S_HDR) && fourth_byte) begin
                word_count <= full_word;
            end
            if (state == S_DATA) begin
                csum_acc <= csum_acc + i_rx_data;
                if (fourth_byte) begin
                    word_idx <= word_idx + IDX_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Imem write port. The strobe is registered so it lands in the cycle
    // after the completing byte; address and data stay put until the next
    // write so the memory side can sample them late if it wants to.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_we    <= 1'b0;
            o_waddr <= 32'd0;
            o_wdata <= 32'd0;
        end else begin
            o_we <= 1'b0;
            if (write_now) begin
                o_we    <= 1'b1;
                o_waddr <= BASE_ADDR + (32'(word_idx) << 2);
                o_wdata <= full_word;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status outputs are pure decodes of the state register
    // ------------------------------------------------------------------------
    assign o_rx_ready  = receiving;
    assign o_busy      = receiving;
    assign o_done      = (state == S_DONE);
    assign o_error     = (state == S_ERR);
    assign o_cpu_reset = (state != S_DONE);

endmodule
